// File: rtl/gather_credit_returner_pkg.sv
// Shared definitions for the gather credit returner: flit type codes,
// default batching parameters and the framing checker state type.
package gather_credit_returner_pkg;

    // Flit type codes as carried on the ejection port; 2'b00 is not a legal flit
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    // Default gather packet length and credit batching behaviour
    localparam int unsigned GATHER_FCPL        = 16;
    localparam int unsigned GATHER_RET_THRESH  = 14;
    localparam int unsigned GATHER_RET_TIMEOUT = 64;

    // All counters and credit values are carried as 32-bit unsigned
    localparam int unsigned CNT_W = 32;

    // Framing checker: waiting for a HEAD, or inside a packet
    typedef enum logic {
        EXP_HEAD = 1'b0,
        IN_PKT   = 1'b1
    } chk_state_e;

    // Number of BODY flits in a well-formed packet of the given length
    function automatic logic [CNT_W-1:0] bodiesPerPkt(input int unsigned fcpl);
        return CNT_W'(fcpl - 2);
    endfunction

endpackage

// File: rtl/gather_credit_returner_if.sv
// Ejection-side bundle of the gather credit returner: the consumer handshake
// coming in and the credit / status values going out.
interface gather_credit_returner_if;
    import gather_credit_returner_pkg::*;

    logic             fire;
    logic [1:0]       flit_type;
    logic [CNT_W-1:0] credit_upd;
    logic [CNT_W-1:0] pending_cnt;
    logic [CNT_W-1:0] pkt_cnt;
    logic             proto_err;

    // Side that drives the ejection handshake and observes returned credit
    modport master (
        output fire,
        output flit_type,
        input  credit_upd,
        input  pending_cnt,
        input  pkt_cnt,
        input  proto_err
    );

    // The credit returner itself
    modport slave (
        input  fire,
        input  flit_type,
        output credit_upd,
        output pending_cnt,
        output pkt_cnt,
        output proto_err
    );

endinterface

// File: rtl/gather_flit_checker.sv
// Framing checker for gather packets: expects HEAD, FCpl-2 BODY, TAIL.
// Counts complete packets and raises a sticky error on any framing violation.
module gather_flit_checker
    import gather_credit_returner_pkg::*;
#(
    parameter int unsigned FCpl = GATHER_FCPL
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fire_i,
    input  logic [1:0]       flitType_i,
    output logic [CNT_W-1:0] pktCnt_o,
    output logic             protoErr_o
);

    localparam logic [CNT_W-1:0] BODY_PER_PKT = bodiesPerPkt(FCpl);

    chk_state_e       state_q, state_d;
    logic [CNT_W-1:0] bodyCnt_q, bodyCnt_d;
    logic [CNT_W-1:0] pktCnt_q, pktCnt_d;
    logic             protoErr_q, protoErr_d;

    // Checker state, body counter, packet counter and sticky error register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= EXP_HEAD;
            bodyCnt_q  <= '0;
            pktCnt_q   <= '0;
            protoErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bodyCnt_q  <= bodyCnt_d;
            pktCnt_q   <= pktCnt_d;
            protoErr_q <= protoErr_d;
        end
    end

    // Framing rules; the body counter stops one past a full packet so an
    // overlong packet can never wrap back into looking well-formed
    always_comb begin
        state_d    = state_q;
        bodyCnt_d  = bodyCnt_q;
        pktCnt_d   = pktCnt_q;
        protoErr_d = protoErr_q;
        if (fire_i) begin
            case (flitType_i)
                FLIT_HEAD: begin
                    if (state_q == IN_PKT) begin
                        protoErr_d = 1'b1;
                    end
                    state_d   = IN_PKT;
                    bodyCnt_d = '0;
                end
                FLIT_BODY: begin
                    if (state_q == EXP_HEAD) begin
                        protoErr_d = 1'b1;
                    end else begin
                        if (bodyCnt_q >= BODY_PER_PKT) begin
                            protoErr_d = 1'b1;
                        end
                        if (bodyCnt_q <= BODY_PER_PKT) begin
                            bodyCnt_d = bodyCnt_q + 1'b1;
                        end
                    end
                end
                FLIT_TAIL: begin
                    if (state_q == EXP_HEAD) begin
                        protoErr_d = 1'b1;
                    end else begin
                        if (bodyCnt_q == BODY_PER_PKT) begin
                            pktCnt_d = pktCnt_q + 1'b1;
                        end else begin
                            protoErr_d = 1'b1;
                        end
                        state_d = EXP_HEAD;
                    end
                end
                default: begin
                    protoErr_d = 1'b1;
                end
            endcase
        end
    end

    assign pktCnt_o   = pktCnt_q;
    assign protoErr_o = protoErr_q;

endmodule

// File: rtl/gather_credit_returner.sv
// Destination-side credit returner for gather flow control. Accumulates one
// credit per drained BODY flit and hands them back as single-cycle batched
// values, flushing on threshold, on packet TAIL, or after an idle timeout.
module gather_credit_returner
    import gather_credit_returner_pkg::*;
#(
    parameter int unsigned isFCdst     = 0,
    parameter int unsigned FCpl        = GATHER_FCPL,
    parameter int unsigned RET_THRESH  = GATHER_RET_THRESH,
    parameter int unsigned RET_TIMEOUT = GATHER_RET_TIMEOUT
) (
    input logic                     clk,
    input logic                     rstn,
    gather_credit_returner_if.slave ej_if
);

    localparam logic             ENABLED      = (isFCdst != 0);
    localparam logic [CNT_W-1:0] THRESH       = CNT_W'(RET_THRESH);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RET_TIMEOUT - 1);

    // On a non-destination node every fire is masked, so all state stays at reset
    logic fireEn;
    logic bodyFire;
    logic tailFire;

    assign fireEn   = ej_if.fire & ENABLED;
    assign bodyFire = fireEn && (ej_if.flit_type == FLIT_BODY);
    assign tailFire = fireEn && (ej_if.flit_type == FLIT_TAIL);

    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] creditUpd_q, creditUpd_d;
    logic [CNT_W-1:0] nxtPending;
    logic             flush;

    // Accumulator, idle timer and the registered credit pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q   <= '0;
            timer_q     <= '0;
            creditUpd_q <= '0;
        end else begin
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            creditUpd_q <= creditUpd_d;
        end
    end

    // Flush decision: the whole batch including this cycle's BODY goes out at once
    always_comb begin
        nxtPending  = pending_q + {{(CNT_W-1){1'b0}}, bodyFire};
        flush       = (nxtPending >= THRESH)
                    || (tailFire && (nxtPending != '0))
                    || ((timer_q == TIMEOUT_LAST) && (nxtPending != '0) && !bodyFire);
        pending_d   = nxtPending;
        timer_d     = '0;
        creditUpd_d = '0;
        if (flush) begin
            creditUpd_d = nxtPending;
            pending_d   = '0;
        end else if (!bodyFire && (pending_q != '0)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    logic [CNT_W-1:0] pktCnt;
    logic             protoErr;

    gather_flit_checker #(
        .FCpl (FCpl)
    ) u_checker (
        .clk        (clk),
        .rstn       (rstn),
        .fire_i     (fireEn),
        .flitType_i (ej_if.flit_type),
        .pktCnt_o   (pktCnt),
        .protoErr_o (protoErr)
    );

    assign ej_if.credit_upd  = creditUpd_q;
    assign ej_if.pending_cnt = pending_q;
    assign ej_if.pkt_cnt     = pktCnt;
    assign ej_if.proto_err   = protoErr;

endmodule

// File: tb/tb_gather_credit_returner.sv
// Testbench for gather_credit_returner: three instances (threshold 14,
// threshold 4 with a short timeout, and an inert non-destination node) all see
// the same ejection traffic and are compared against a behavioural model.
module tb_gather_credit_returner;
    import gather_credit_returner_pkg::*;

    localparam int NCFG = 3;
    localparam int FCPL = 16;
    localparam int CFG_EN [NCFG] = '{1, 1, 0};
    localparam int CFG_TH [NCFG] = '{14, 4, 14};
    localparam int CFG_TO [NCFG] = '{64, 5, 64};

    logic       clk;
    logic       rstn;
    logic       fire;
    logic [1:0] flitType;

    int checks = 0;
    int errors = 0;

    // Reference model state per configuration
    int mPend  [NCFG];
    int mTimer [NCFG];
    int mCred  [NCFG];
    int mPkt   [NCFG];
    int mBc    [NCFG];
    bit mErr   [NCFG];
    bit mInPkt [NCFG];

    int sumA;
    int sumB;
    int pulsesB[$];

    gather_credit_returner_if ifA ();
    gather_credit_returner_if ifB ();
    gather_credit_returner_if ifC ();

    assign ifA.fire = fire;
    assign ifA.flit_type = flitType;
    assign ifB.fire = fire;
    assign ifB.flit_type = flitType;
    assign ifC.fire = fire;
    assign ifC.flit_type = flitType;

    gather_credit_returner #(
        .isFCdst(1), .FCpl(FCPL), .RET_THRESH(14), .RET_TIMEOUT(64)
    ) dutA (
        .clk(clk), .rstn(rstn), .ej_if(ifA)
    );

    gather_credit_returner #(
        .isFCdst(1), .FCpl(FCPL), .RET_THRESH(4), .RET_TIMEOUT(5)
    ) dutB (
        .clk(clk), .rstn(rstn), .ej_if(ifB)
    );

    gather_credit_returner #(
        .isFCdst(0), .FCpl(FCPL), .RET_THRESH(14), .RET_TIMEOUT(64)
    ) dutC (
        .clk(clk), .rstn(rstn), .ej_if(ifC)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the end of the test");
        $fatal(1, "[TB] watchdog");
    end

    task automatic expectVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NCFG; c++) begin
            mPend[c]  = 0;
            mTimer[c] = 0;
            mCred[c]  = 0;
            mPkt[c]   = 0;
            mBc[c]    = 0;
            mErr[c]   = 1'b0;
            mInPkt[c] = 1'b0;
        end
    endtask

    // One clock edge of the specified behaviour for configuration c
    task automatic modelStep(input int c, input logic f, input logic [1:0] t);
        bit bf;
        bit tf;
        bit fl;
        int nxt;
        if (CFG_EN[c] == 0) return;
        bf  = f && (t == FLIT_BODY);
        tf  = f && (t == FLIT_TAIL);
        nxt = mPend[c] + (bf ? 1 : 0);
        fl  = (nxt >= CFG_TH[c]) || (tf && nxt > 0)
           || (mTimer[c] == CFG_TO[c] - 1 && nxt > 0 && !bf);
        if (fl) begin
            mCred[c]  = nxt;
            mPend[c]  = 0;
            mTimer[c] = 0;
        end else begin
            mCred[c]  = 0;
            mTimer[c] = (bf || mPend[c] == 0) ? 0 : mTimer[c] + 1;
            mPend[c]  = nxt;
        end
        if (f) begin
            case (t)
                FLIT_HEAD: begin
                    if (mInPkt[c]) mErr[c] = 1'b1;
                    mInPkt[c] = 1'b1;
                    mBc[c]    = 0;
                end
                FLIT_BODY: begin
                    if (!mInPkt[c]) mErr[c] = 1'b1;
                    else begin
                        mBc[c]++;
                        if (mBc[c] > FCPL - 2) mErr[c] = 1'b1;
                    end
                end
                FLIT_TAIL: begin
                    if (!mInPkt[c]) mErr[c] = 1'b1;
                    else begin
                        if (mBc[c] == FCPL - 2) mPkt[c]++;
                        else mErr[c] = 1'b1;
                        mInPkt[c] = 1'b0;
                    end
                end
                default: mErr[c] = 1'b1;
            endcase
        end
    endtask

    task automatic checkOutput(input int c);
        logic [31:0] oCred;
        logic [31:0] oPend;
        logic [31:0] oPkt;
        logic        oErr;
        case (c)
            0: begin
                oCred = ifA.credit_upd; oPend = ifA.pending_cnt;
                oPkt = ifA.pkt_cnt; oErr = ifA.proto_err;
            end
            1: begin
                oCred = ifB.credit_upd; oPend = ifB.pending_cnt;
                oPkt = ifB.pkt_cnt; oErr = ifB.proto_err;
            end
            default: begin
                oCred = ifC.credit_upd; oPend = ifC.pending_cnt;
                oPkt = ifC.pkt_cnt; oErr = ifC.proto_err;
            end
        endcase
        expectVal($sformatf("cfg%0d credit_upd", c), oCred, 32'(mCred[c]));
        expectVal($sformatf("cfg%0d pending_cnt", c), oPend, 32'(mPend[c]));
        expectVal($sformatf("cfg%0d pkt_cnt", c), oPkt, 32'(mPkt[c]));
        expectVal($sformatf("cfg%0d proto_err", c), {31'b0, oErr}, {31'b0, mErr[c]});
    endtask

    task automatic checkAll();
        for (int c = 0; c < NCFG; c++) checkOutput(c);
    endtask

    // Drive one cycle of ejection traffic, then compare all instances #1 after the edge
    task automatic applyStimulus(input logic f, input logic [1:0] t);
        fire = f;
        flitType = t;
        @(posedge clk);
        for (int c = 0; c < NCFG; c++) modelStep(c, f, t);
        #1;
        checkAll();
        sumA += int'(ifA.credit_upd);
        sumB += int'(ifB.credit_upd);
        if (ifB.credit_upd != 0) pulsesB.push_back(int'(ifB.credit_upd));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'($urandom));
    endtask

    task automatic doReset();
        fire = 1'b0;
        rstn = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic sendPacket(input int nBody);
        applyStimulus(1'b1, FLIT_HEAD);
        for (int i = 0; i < nBody; i++) applyStimulus(1'b1, FLIT_BODY);
        applyStimulus(1'b1, FLIT_TAIL);
    endtask

    initial begin
        int hit;
        logic [31:0] hitVal;
        int nBody;
        bit corrupt;

        rstn = 1'b1;
        fire = 1'b0;
        flitType = 2'b00;
        #1;
        rstn = 1'b0;
        #2;
        modelReset();
        checkAll();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        $display("[TB] reset released");

        // Full packet: threshold 14 flushes once, threshold 4 pulses 4,4,4,2
        sumA = 0;
        sumB = 0;
        pulsesB.delete();
        applyStimulus(1'b1, FLIT_HEAD);
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, FLIT_BODY);
        expectVal("t1 credit after 14th BODY", ifA.credit_upd, 32'd14);
        applyStimulus(1'b1, FLIT_TAIL);
        expectVal("t1 credit at TAIL", ifA.credit_upd, 32'd0);
        expectVal("t1 pkt_cnt", ifA.pkt_cnt, 32'd1);
        expectVal("t1 proto_err", {31'b0, ifA.proto_err}, 32'd0);
        expectVal("t2 pulse after TAIL", ifB.credit_upd, 32'd2);
        applyStimulus(1'b0, 2'b00);
        expectVal("t1 pulse width", ifA.credit_upd, 32'd0);
        expectVal("t1 credit sum", 32'(sumA), 32'd14);
        expectVal("t2 credit sum", 32'(sumB), 32'd14);
        expectVal("t2 pulse count", 32'(pulsesB.size()), 32'd4);
        if (pulsesB.size() == 4) begin
            expectVal("t2 pulse0", 32'(pulsesB[0]), 32'd4);
            expectVal("t2 pulse1", 32'(pulsesB[1]), 32'd4);
            expectVal("t2 pulse2", 32'(pulsesB[2]), 32'd4);
            expectVal("t2 pulse3", 32'(pulsesB[3]), 32'd2);
        end

        // Partial batch then idle: timeout flush exactly 64 cycles after the last BODY
        applyStimulus(1'b1, FLIT_HEAD);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, FLIT_BODY);
        hit = 0;
        hitVal = '0;
        for (int j = 1; j <= 100 && hit == 0; j++) begin
            applyStimulus(1'b0, 2'($urandom));
            if (ifA.credit_upd != 0) begin
                hit = j;
                hitVal = ifA.credit_upd;
            end
        end
        expectVal("t3 timeout latency", 32'(hit), 32'd64);
        expectVal("t3 timeout credit", hitVal, 32'd5);
        doReset();

        // Short packet: sticky framing error, credit still returned on TAIL
        sendPacket(3);
        expectVal("t4 credit at TAIL", ifA.credit_upd, 32'd3);
        expectVal("t4 proto_err", {31'b0, ifA.proto_err}, 32'd1);
        expectVal("t4 pkt_cnt", ifA.pkt_cnt, 32'd0);
        idleCycles(3);
        expectVal("t4 proto_err sticky", {31'b0, ifA.proto_err}, 32'd1);
        doReset();

        // Reset in the middle of a batch discards it; a fresh packet returns 14
        applyStimulus(1'b1, FLIT_HEAD);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, FLIT_BODY);
        expectVal("t6 pending before reset", ifA.pending_cnt, 32'd7);
        fire = 1'b0;
        rstn = 1'b0;
        #1;
        expectVal("t6 pending in reset", ifA.pending_cnt, 32'd0);
        expectVal("t6 credit in reset", ifA.credit_upd, 32'd0);
        modelReset();
        checkAll();
        @(negedge clk);
        rstn = 1'b1;
        sumA = 0;
        sendPacket(14);
        idleCycles(2);
        expectVal("t6 credit sum after reset", 32'(sumA), 32'd14);
        expectVal("t6 pkt_cnt after reset", ifA.pkt_cnt, 32'd1);
        doReset();

        // Randomized traffic: mostly well-formed packets with gaps, some corrupted
        $display("[TB] random traffic phase");
        for (int p = 0; p < 40; p++) begin
            corrupt = ($urandom_range(0, 3) == 0);
            nBody = corrupt ? int'($urandom_range(0, 17)) : FCPL - 2;
            idleCycles(($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 1)));
            applyStimulus(1'b1, FLIT_HEAD);
            for (int b = 0; b < nBody; b++) begin
                idleCycles(($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 1)));
                applyStimulus(1'b1, FLIT_BODY);
            end
            idleCycles(int'($urandom_range(0, 2)));
            applyStimulus(1'b1, corrupt ? 2'($urandom) : FLIT_TAIL);
        end
        for (int i = 0; i < 200; i++) applyStimulus(1'($urandom), 2'($urandom));
        idleCycles(70);
        expectVal("t5 inert credit_upd", ifC.credit_upd, 32'd0);
        expectVal("t5 inert pending_cnt", ifC.pending_cnt, 32'd0);
        expectVal("t5 inert pkt_cnt", ifC.pkt_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
